// File: rtl/motor_ramp_ctrl.sv
// Slew-rate limited left/right motor command generator with emergency stop.
// Latency: outputs step by at most STEP once every DIV clocks; done rises one cycle after both sides reach target.
// Backpressure: cmd_rdy is high only while IDLE with estop low; cmd_vld is ignored at all other times.
//
// Ports:
//   clk, rst          - system clock, asynchronous active-high reset
//   tgt_lft, tgt_rht  - signed 11-bit target pair, accepted on cmd_vld & cmd_rdy
//   cmd_vld, cmd_rdy  - command handshake
//   estop             - level-sensitive emergency stop (ramps both sides to 0)
//   lft, rht          - registered signed motor commands
//   busy              - high in RAMP or ESTOP
//   done              - one-cycle pulse when a ramp reaches its target
module motor_ramp_ctrl #(
  parameter int STEP = 16,
  parameter int DIV  = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [10:0] tgt_lft,
  input  logic signed [10:0] tgt_rht,
  input  logic               cmd_vld,
  output logic               cmd_rdy,
  input  logic               estop,
  output logic signed [10:0] lft,
  output logic signed [10:0] rht,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RAMP  = 2'd1;
  localparam logic [1:0] ST_ESTOP = 2'd2;

  localparam logic [15:0]        TICK_LAST = 16'(DIV - 1);
  // STEP fits an 11-bit signed value, so the step itself is done at output
  // width; the magnitude test uses 12 bits because target-current can reach
  // +/-2047.
  localparam logic signed [11:0] STEP_W    = 12'(STEP);
  localparam logic signed [10:0] STEP_N    = 11'(STEP);

  logic [1:0]         state;
  logic [15:0]        count;
  logic signed [10:0] lft_tgt;
  logic signed [10:0] rht_tgt;
  logic               tick;
  logic               at_tgt;

  // Move cur toward tgt by at most STEP. When |diff| > STEP the stepped
  // value lies strictly between cur and tgt, so it cannot leave the 11-bit
  // range and the 11-bit add cannot wrap.
  function automatic logic signed [10:0] step_toward(
    input logic signed [10:0] cur,
    input logic signed [10:0] tgt
  );
    logic signed [11:0] diff;
    logic signed [11:0] mag;
    logic signed [10:0] nxt;
    diff = {tgt[10], tgt} - {cur[10], cur};
    mag  = diff[11] ? -diff : diff;
    if (mag <= STEP_W) begin
      nxt = tgt;
    end else if (diff[11]) begin
      nxt = cur - STEP_N;
    end else begin
      nxt = cur + STEP_N;
    end
    return nxt;
  endfunction

  assign busy    = (state != ST_IDLE);
  assign cmd_rdy = (state == ST_IDLE) && !estop;
  // Counter sits at 0 in IDLE and DIV >= 2, so tick can only fire when busy.
  assign tick    = (count == TICK_LAST);
  assign at_tgt  = (lft == lft_tgt) && (rht == rht_tgt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      count   <= '0;
      lft     <= '0;
      rht     <= '0;
      lft_tgt <= '0;
      rht_tgt <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;

      if (tick) begin
        lft <= step_toward(lft, lft_tgt);
        rht <= step_toward(rht, rht_tgt);
      end

      if (state == ST_IDLE) begin
        count <= '0;
      end else begin
        count <= tick ? 16'd0 : count + 16'd1;
      end

      case (state)
        ST_IDLE: begin
          if (estop) begin
            state   <= ST_ESTOP;
            lft_tgt <= '0;
            rht_tgt <= '0;
          end else if (cmd_vld && cmd_rdy) begin
            state   <= ST_RAMP;
            lft_tgt <= tgt_lft;
            rht_tgt <= tgt_rht;
          end
        end
        ST_RAMP: begin
          if (estop) begin
            // Abort: no done pulse, keep the tick phase and ramp to zero.
            state   <= ST_ESTOP;
            lft_tgt <= '0;
            rht_tgt <= '0;
          end else if (at_tgt) begin
            state <= ST_IDLE;
            done  <= 1'b1;
            count <= '0;
          end
        end
        ST_ESTOP: begin
          lft_tgt <= '0;
          rht_tgt <= '0;
          if (!estop && (lft == 11'sd0) && (rht == 11'sd0)) begin
            state <= ST_IDLE;
            count <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Bench for motor_ramp_ctrl: scoreboard of expected output changes and done pulses.
// Expected trajectories come from a closed-form slew model (value after k ticks).
// Monitor compares on every observed output change/done, decoupled from stimulus.
module tb_motor_ramp_ctrl;

  localparam int STEP = 16;
  localparam int DIV  = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [10:0] tgt_lft;
  logic signed [10:0] tgt_rht;
  logic               cmd_vld;
  logic               cmd_rdy;
  logic               estop;
  logic signed [10:0] lft;
  logic signed [10:0] rht;
  logic               busy;
  logic               done;

  motor_ramp_ctrl #(.STEP(STEP), .DIV(DIV)) dut (
    .clk     (clk),
    .rst     (rst),
    .tgt_lft (tgt_lft),
    .tgt_rht (tgt_rht),
    .cmd_vld (cmd_vld),
    .cmd_rdy (cmd_rdy),
    .estop   (estop),
    .lft     (lft),
    .rht     (rht),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_done;
    int l;
    int r;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int  cyc    = 0;
  int  vecs   = 0;
  int  errs   = 0;
  bit  mon_en = 1'b0;
  int  cur_l  = 0;
  int  cur_r  = 0;
  int  last_a = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Position after k ticks when slewing from c0 toward t at STEP per tick.
  function automatic int pos_at(input int c0, input int t, input int k);
    int d;
    int ad;
    d  = t - c0;
    ad = (d < 0) ? -d : d;
    if (ad <= k * STEP) return t;
    return (d > 0) ? c0 + k * STEP : c0 - k * STEP;
  endfunction

  function automatic int ticks_needed(input int c0, input int t);
    int ad;
    ad = (t > c0) ? t - c0 : c0 - t;
    return (ad + STEP - 1) / STEP;
  endfunction

  // Push one change event per tick k = 1..n; tick k lands on edge base + DIV*k.
  task automatic push_traj(input int l0, input int r0, input int tl, input int tr,
                           input int base, input int kofs);
    int n;
    ev_t e;
    n = ticks_needed(l0, tl);
    if (ticks_needed(r0, tr) > n) n = ticks_needed(r0, tr);
    for (int k = 1; k <= n; k++) begin
      e.is_done = 1'b0;
      e.l   = pos_at(l0, tl, k);
      e.r   = pos_at(r0, tr, k);
      e.cyc = base + DIV * (k + kofs);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: samples 2 time units after each rising edge.
  logic signed [10:0] last_lv = '0;
  logic signed [10:0] last_rv = '0;
  always begin
    ev_t e;
    int  l;
    int  r;
    @(posedge clk);
    #2;
    l = int'(lft);
    r = int'(rht);
    if (mon_en) begin
      if (lft !== last_lv || rht !== last_rv) begin
        vecs++;
        if (exp_q.size() == 0) begin
          errs++;
          $display("FAIL step: unexpected lft=%0d rht=%0d at edge %0d", l, r, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.is_done || e.l != l || e.r != r || e.cyc != cyc) begin
            errs++;
            $display("FAIL step: got lft=%0d rht=%0d at edge %0d, expected done=%0d lft=%0d rht=%0d at edge %0d",
                     l, r, cyc, e.is_done, e.l, e.r, e.cyc);
          end
        end
      end
      if (done === 1'b1) begin
        vecs++;
        if (exp_q.size() == 0) begin
          errs++;
          $display("FAIL done: unexpected pulse at edge %0d", cyc);
        end else begin
          e = exp_q.pop_front();
          if (!e.is_done || e.cyc != cyc) begin
            errs++;
            $display("FAIL done: pulse at edge %0d, expected done=%0d at edge %0d", cyc, e.is_done, e.cyc);
          end
        end
        chk("rdy_after_done", int'(cmd_rdy), 1);
      end
    end
    last_lv = lft;
    last_rv = rht;
  end

  // Present a target pair for one cycle; it is sampled at edge a = cyc+1.
  task automatic issue_cmd(input int tl, input int tr);
    int  n;
    ev_t e;
    @(negedge clk);
    chk("rdy_before_cmd", int'(cmd_rdy), 1);
    last_a  = cyc + 1;
    tgt_lft = 11'(tl);
    tgt_rht = 11'(tr);
    cmd_vld = 1'b1;
    push_traj(cur_l, cur_r, tl, tr, last_a, 0);
    n = ticks_needed(cur_l, tl);
    if (ticks_needed(cur_r, tr) > n) n = ticks_needed(cur_r, tr);
    e.is_done = 1'b1;
    e.l   = tl;
    e.r   = tr;
    e.cyc = last_a + DIV * n + 1;
    exp_q.push_back(e);
    cur_l = tl;
    cur_r = tr;
    @(negedge clk);
    cmd_vld = 1'b0;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 3000;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() != 0) begin
      vecs++;
      errs++;
      $display("FAIL timeout: %0d expected events never seen", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tl;
    int tr;
    int n;
    rst     = 1'b1;
    tgt_lft = '0;
    tgt_rht = '0;
    cmd_vld = 1'b0;
    estop   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_lft", int'(lft), 0);
    chk("reset_rht", int'(rht), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    chk("idle_rdy", int'(cmd_rdy), 1);

    // Equal target: done one cycle after acceptance, no movement.
    issue_cmd(0, 0);
    wait_idle();

    // Basic ramp: 16/32/40 and -16/-32/-40 on edges a+4/8/12, done at a+13.
    issue_cmd(40, -40);
    wait_idle();
    chk("basic_lft", int'(lft), 40);
    chk("basic_rht", int'(rht), -40);
    issue_cmd(0, 0);
    wait_idle();

    // cmd_vld together with estop in IDLE: not accepted, outputs stay 0.
    @(negedge clk);
    tgt_lft = 11'sd100;
    tgt_rht = 11'sd100;
    cmd_vld = 1'b1;
    estop   = 1'b1;
    @(negedge clk);
    cmd_vld = 1'b0;
    chk("simul_busy", int'(busy), 1);
    chk("simul_rdy", int'(cmd_rdy), 0);
    repeat (10) @(negedge clk);
    estop = 1'b0;
    @(negedge clk);
    chk("simul_exit_busy", int'(busy), 0);
    chk("simul_lft", int'(lft), 0);

    // Command during RAMP is ignored; original target reached.
    issue_cmd(64, -64);
    repeat (3) @(negedge clk);
    tgt_lft = 11'sd500;
    tgt_rht = 11'sd500;
    cmd_vld = 1'b1;
    @(negedge clk);
    cmd_vld = 1'b0;
    wait_idle();

    // Full-scale swings both directions on both sides.
    issue_cmd(-1024, 1023);
    wait_idle();
    issue_cmd(1023, -1024);
    wait_idle();
    chk("full_lft", int'(lft), 1023);
    chk("full_rht", int'(rht), -1024);

    // Randomized targets, some with an ignored command mid-ramp.
    for (int i = 0; i < 10; i++) begin
      tl = int'($urandom_range(2047)) - 1024;
      tr = (i % 3 == 0) ? cur_r + int'($urandom_range(40)) - 20 : int'($urandom_range(2047)) - 1024;
      if (tr > 1023) tr = 1023;
      if (tr < -1024) tr = -1024;
      n = ticks_needed(cur_l, tl);
      if (ticks_needed(cur_r, tr) > n) n = ticks_needed(cur_r, tr);
      issue_cmd(tl, tr);
      if (n > 0 && $urandom_range(1) == 1) begin
        repeat (int'($urandom_range(DIV * n - 1))) @(negedge clk);
        tgt_lft = 11'($urandom_range(2047));
        tgt_rht = 11'($urandom_range(2047));
        cmd_vld = 1'b1;
        @(negedge clk);
        cmd_vld = 1'b0;
      end
      wait_idle();
      repeat (int'($urandom_range(3))) @(negedge clk);
    end
    issue_cmd(0, 0);
    wait_idle();

    // Estop mid-ramp at lft=32 / rht=-32 heading to 200 / -100.
    issue_cmd(200, -100);
    repeat (9) @(negedge clk);
    chk("estop_pre_lft", int'(lft), 32);
    estop = 1'b1;
    exp_q.delete();
    push_traj(32, -32, 0, 0, last_a, 2);
    cur_l = 0;
    cur_r = 0;
    repeat (10) @(negedge clk);
    chk("estop_busy", int'(busy), 1);
    chk("estop_rdy", int'(cmd_rdy), 0);
    chk("estop_lft", int'(lft), 0);
    estop = 1'b0;
    @(negedge clk);
    chk("estop_exit_busy", int'(busy), 0);
    chk("estop_exit_rdy", int'(cmd_rdy), 1);
    wait_idle();

    // Reset mid-ramp at lft=48: outputs clear without a clock edge.
    issue_cmd(100, 100);
    repeat (12) @(negedge clk);
    chk("rst_pre_lft", int'(lft), 48);
    mon_en = 1'b0;
    exp_q.delete();
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async_lft", int'(lft), 0);
    chk("rst_async_rht", int'(rht), 0);
    chk("rst_async_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    cur_l = 0;
    cur_r = 0;
    @(negedge clk);
    chk("rst_after_rdy", int'(cmd_rdy), 1);
    chk("rst_after_busy", int'(busy), 0);
    mon_en = 1'b1;
    issue_cmd(-30, 17);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/motor_ramp_ctrl.md
MOTOR_RAMP_CTRL -- requirements
Module: motor_ramp_ctrl

Interface
REQ-001 SHALL have parameter STEP, default 16, meaning the maximum magnitude change applied to each command per ramp tick (range 1..1023).
REQ-002 SHALL have parameter DIV, default 1024, meaning clocks per ramp tick (range 2..65535).
REQ-003 SHALL have port clk  input  1  single system clock; all state changes occur on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port tgt_lft  input  11  signed target left command (-1024..1023).
REQ-006 SHALL have port tgt_rht  input  11  signed target right command.
REQ-007 SHALL have port cmd_vld  input  1  target pair is valid.
REQ-008 SHALL have port cmd_rdy  output  1  block can accept a target pair.
REQ-009 SHALL have port estop  input  1  level-sensitive emergency stop.
REQ-010 SHALL have port lft  output  11  signed registered left command, driving the motor controller lft input.
REQ-011 SHALL have port rht  output  11  signed registered right command, driving the motor controller rht input.
REQ-012 SHALL have port busy  output  1  high in the RAMP or ESTOP states.
REQ-013 SHALL have port done  output  1  one-cycle pulse when a ramp completes.

Function
REQ-014 SHALL implement a state machine with states IDLE, RAMP and ESTOP; all outputs SHALL be registered or decoded from state only.
REQ-015 SHALL drive cmd_rdy = 1 only in IDLE with estop = 0.
REQ-016 SHALL accept a command when cmd_vld and cmd_rdy are both 1: latch tgt_lft/tgt_rht internally, clear the tick counter to 0, and move IDLE->RAMP.
REQ-017 SHALL run a tick counter from 0 to DIV-1 and wrap; tick SHALL be asserted in the cycle where count == DIV-1; the counter SHALL run freely in RAMP and ESTOP and hold at 0 in IDLE.
REQ-018 SHALL update each command on tick, per side, as follows:
- diff = target - current, computed in 12-bit signed arithmetic.
- If |diff| <= STEP, current = target.
- Otherwise, current = current + STEP * sign(diff).
- The result SHALL never leave the range -1024..1023 and SHALL never wrap.
REQ-019 SHALL, in RAMP, compare current to target every cycle; when both sides are equal it SHALL move to IDLE and pulse done for exactly one cycle, in the cycle after equality is first registered.
REQ-020 SHALL, when the accepted target equals the current outputs, move RAMP->IDLE with done one cycle after acceptance, with no step taken.
REQ-021 SHALL ignore cmd_vld in RAMP and ESTOP; no queueing and no target overwrite.
REQ-022 SHALL treat estop = 1 in any state as follows:
- Move to ESTOP on the next edge.
- Force both internal targets to 0.
- Continue stepping on ticks using the REQ-018 rule.
- Any in-progress ramp is aborted with no done pulse.
REQ-023 SHALL give estop priority over cmd_vld in the same cycle; the command is not accepted.
REQ-024 SHALL exit ESTOP to IDLE only when estop = 0 and lft = rht = 0; no done pulse on this exit.
REQ-025 SHALL change lft/rht only on ticks, by at most STEP per tick per side.

Reset
REQ-026 SHALL, while rst = 1, immediately (asynchronously) force:
- state = IDLE
- lft = 0, rht = 0
- internal targets = 0
- tick counter = 0
- done = 0, busy = 0
REQ-027 SHALL, on rst assertion mid-ramp, abandon the ramp; after rst deasserts the block SHALL be in IDLE with cmd_rdy = 1 when estop = 0.

Verification
REQ-028 SHALL run all scenarios with DIV = 4 and STEP = 16.
REQ-029 SHALL cover basic ramp: from reset, accept tgt_lft = 40, tgt_rht = -40 at cycle 0.
- lft SHALL read 16, 32, 40 after the edges at cycles 4, 8, 12.
- rht SHALL read -16, -32, -40 after the same edges.
- done SHALL pulse at cycle 13; cmd_rdy SHALL then be 1.
REQ-030 SHALL cover full-scale ramp: starting from lft = -1024, accept tgt_lft = 1023.
- lft SHALL step 16 per tick, reaching 1008 after 127 ticks and 1023 on tick 128.
- lft SHALL never overflow.
REQ-031 SHALL cover estop mid-ramp: while at lft = 32 heading to 200, assert estop.
- State SHALL move to ESTOP with no done pulse.
- lft SHALL step 16 then 0.
- After estop deasserts with lft = rht = 0, the block SHALL be in IDLE.
REQ-032 SHALL cover the simultaneous event: cmd_vld and estop both 1 in IDLE.
- The command SHALL not be accepted and outputs SHALL remain 0.
- A cmd_vld pulse during RAMP SHALL be ignored; the original target is reached.
REQ-033 SHALL cover the equal-target case: with outputs at 0, accept target (0, 0).
- done SHALL pulse one cycle after acceptance.
- lft/rht SHALL not change.
REQ-034 SHALL cover reset mid-operation: assert rst at lft = 48 during RAMP.
- lft = rht = 0 and busy = 0 SHALL hold immediately, without waiting for a clock edge.
- After rst deasserts, cmd_rdy = 1 on the next cycle.
